// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a registered result, masked shifts and zero/illegal flags.
// Define ALU_SEQ_MULDIV_EN to build the iterative MUL/DIV/REM datapath; otherwise those codes are illegal.
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_function,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_equal_zero,
    output logic             illegal_op
);

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_SLL  = 5'b00011;
    localparam logic [4:0] OP_SRL  = 5'b00100;
    localparam logic [4:0] OP_SRA  = 5'b00101;
    localparam logic [4:0] OP_SEQ  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_SLTU = 5'b01000;
    localparam logic [4:0] OP_XOR  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_AND  = 5'b01011;

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [4:0] OP_MUL   = 5'b01100;
    localparam logic [4:0] OP_MULH  = 5'b01101;
    localparam logic [4:0] OP_MULHU = 5'b01110;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_REM   = 5'b10001;
    localparam logic [4:0] OP_REMU  = 5'b10010;

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
`else
    typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    logic             accept;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0] simpleRes;
    logic             simpleIllegal;

    assign in_ready          = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept            = in_valid && in_ready;
    assign out_valid         = (state_q == DONE);
    assign result            = result_q;
    assign result_equal_zero = zero_q;
    assign illegal_op        = illegal_q;
    assign shamt             = operand_b[SHAMT_W-1:0];

`ifdef ALU_SEQ_MULDIV_EN
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   opB_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               neg_q;
    logic [4:0]         op_q;

    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic               startIter;
    logic               divByZero;
    logic               divOverflow;
    logic               signedOp;
    logic               negRes;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic               isMul;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH-1:0]   divDiff;
    logic               divFits;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;
    logic [WIDTH-1:0]   fixRes;

    assign divByZero   = (operand_b == '0);
    assign divOverflow = (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == '1);

    // Signed ops iterate on magnitudes; the sign is re-applied in FIX.
    // A remainder follows the dividend's sign, a quotient/product the XOR of both.
    always_comb begin
        signedOp = (alu_function == OP_MULH) || (alu_function == OP_DIV) ||
                   (alu_function == OP_REM);
        magA     = (signedOp && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        magB     = (signedOp && operand_b[WIDTH-1]) ? -operand_b : operand_b;
        negRes   = 1'b0;
        if ((alu_function == OP_MULH) || (alu_function == OP_DIV)) begin
            negRes = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
        end else if (alu_function == OP_REM) begin
            negRes = operand_a[WIDTH-1];
        end
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    // hi_q holds the partial product/remainder, lo_q the multiplier/quotient.
    always_comb begin
        isMul    = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHU);
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opB_q} : {(WIDTH+1){1'b0}});
        divShift = {hi_q, lo_q[WIDTH-1]};
        divFits  = (divShift >= {1'b0, opB_q});
        divDiff  = divShift[WIDTH-1:0] - opB_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (isMul) begin
            hi_d = mulSum[WIDTH:1];
            lo_d = {mulSum[0], lo_q[WIDTH-1:1]};
        end else begin
            hi_d = divFits ? divDiff : divShift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], divFits};
        end
    end

    always_comb begin
        prodFix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quotFix = neg_q ? -lo_q : lo_q;
        remFix  = neg_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:            fixRes = prodFix[WIDTH-1:0];
            OP_MULH, OP_MULHU: fixRes = prodFix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:   fixRes = quotFix;
            default:           fixRes = remFix;
        endcase
    end
`endif

    // Single-cycle results; divide corner cases resolve here so they skip the iteration.
    always_comb begin
        simpleRes     = '0;
        simpleIllegal = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
        startIter     = 1'b0;
`endif
        case (alu_function)
            OP_ADD:  simpleRes = operand_a + operand_b;
            OP_SUB:  simpleRes = operand_a - operand_b;
            OP_SLL:  simpleRes = operand_a << shamt;
            OP_SRL:  simpleRes = operand_a >> shamt;
            OP_SRA:  simpleRes = $signed(operand_a) >>> shamt;
            OP_SEQ:  simpleRes = {{(WIDTH-1){1'b0}}, operand_a == operand_b};
            OP_SLT:  simpleRes = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            OP_SLTU: simpleRes = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
            OP_XOR:  simpleRes = operand_a ^ operand_b;
            OP_OR:   simpleRes = operand_a | operand_b;
            OP_AND:  simpleRes = operand_a & operand_b;
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL, OP_MULH, OP_MULHU: startIter = 1'b1;
            OP_DIV, OP_REM: begin
                if (divByZero) begin
                    simpleRes = (alu_function == OP_DIV) ? '1 : operand_a;
                end else if (divOverflow) begin
                    simpleRes = (alu_function == OP_DIV) ? operand_a : '0;
                end else begin
                    startIter = 1'b1;
                end
            end
            OP_DIVU, OP_REMU: begin
                if (divByZero) begin
                    simpleRes = (alu_function == OP_DIVU) ? '1 : operand_a;
                end else begin
                    startIter = 1'b1;
                end
            end
`endif
            default: simpleIllegal = 1'b1;
        endcase
    end

    // Control FSM with registered result/flags. DONE accepts the next op while
    // popping the current one, so back-to-back requests see no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            hi_q      <= '0;
            lo_q      <= '0;
            opB_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            op_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (accept && startIter) begin
                        hi_q    <= '0;
                        lo_q    <= magA;
                        opB_q   <= magB;
                        cnt_q   <= '0;
                        neg_q   <= negRes;
                        op_q    <= alu_function;
                        state_q <= BUSY;
                    end else
`endif
                    if (accept) begin
                        result_q  <= simpleRes;
                        zero_q    <= (simpleRes == '0);
                        illegal_q <= simpleIllegal;
                        state_q   <= DONE;
                    end else if ((state_q == DONE) && out_ready) begin
                        state_q <= IDLE;
                    end
                end
`ifdef ALU_SEQ_MULDIV_EN
                BUSY: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q  <= fixRes;
                    zero_q    <= (fixRes == '0);
                    illegal_q <= 1'b0;
                    state_q   <= DONE;
                end
`endif
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq with a queue-based scoreboard and a decoupled monitor.
// Multiply/divide expectations follow ALU_SEQ_MULDIV_EN.
`timescale 1ns/1ps
module tb_alu_seq;

    localparam logic [4:0] C_ADD  = 5'b00001;
    localparam logic [4:0] C_SUB  = 5'b00010;
    localparam logic [4:0] C_SLL  = 5'b00011;
    localparam logic [4:0] C_SRL  = 5'b00100;
    localparam logic [4:0] C_SRA  = 5'b00101;
    localparam logic [4:0] C_SEQ  = 5'b00110;
    localparam logic [4:0] C_SLT  = 5'b00111;
    localparam logic [4:0] C_SLTU = 5'b01000;
    localparam logic [4:0] C_XOR  = 5'b01001;
    localparam logic [4:0] C_OR   = 5'b01010;
    localparam logic [4:0] C_AND  = 5'b01011;
    localparam logic [4:0] C_MUL  = 5'b01100;
    localparam logic [4:0] C_MULH = 5'b01101;
    localparam logic [4:0] C_MULHU = 5'b01110;
    localparam logic [4:0] C_DIV  = 5'b01111;
    localparam logic [4:0] C_DIVU = 5'b10000;
    localparam logic [4:0] C_REM  = 5'b10001;
    localparam logic [4:0] C_REMU = 5'b10010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_function = 5'b0;
    logic [31:0] operand_a = 32'h0;
    logic [31:0] operand_b = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        result_equal_zero;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;

    typedef struct {
        logic [63:0] tag;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t expQ[$];

    alu_seq #(.WIDTH(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .alu_function      (alu_function),
        .operand_a         (operand_a),
        .operand_b         (operand_b),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .result            (result),
        .result_equal_zero (result_equal_zero),
        .illegal_op        (illegal_op)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string what, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, actual, expected);
        end
    endtask

    task automatic pushExpect(input logic [63:0] tag, input logic [31:0] expRes,
                              input logic expIll, input int lat);
        exp_t e;
        e.tag  = tag;
        e.res  = expRes;
        e.zero = (expRes == 32'h0);
        e.ill  = expIll;
        e.lat  = lat;
        e.acc  = cycleCnt;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [63:0] tag, input logic [4:0] fn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input logic expIll, input int lat);
        int guard;
        @(negedge clk);
        in_valid     = 1'b1;
        alu_function = fn;
        operand_a    = a;
        operand_b    = b;
        #1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout %s: in_ready=%0b, required 1", tag, in_ready);
        end else begin
            pushExpect(tag, expRes, expIll, lat);
        end
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        alu_function = 5'b11111;
        operand_a    = 32'hDEADBEEF;
        operand_b    = 32'h0BADF00D;
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while ((expQ.size() != 0 || out_valid) && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (expQ.size() != 0 || out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain timeout: pending=%0d out_valid=%0b, required 0/0", expQ.size(), out_valid);
        end
    endtask

    // Monitor: a result is new on the first cycle out_valid is seen after idle or a handshake.
    initial begin : monitor
        logic prevValid;
        logic prevTaken;
        exp_t e;
        prevValid = 1'b0;
        prevTaken = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prevValid = 1'b0;
                prevTaken = 1'b0;
            end else begin
                if (out_valid && (!prevValid || prevTaken)) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL spurious out_valid: result=0x%08h, required no output", result);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput($sformatf("%s result", e.tag), result, e.res);
                        checkOutput($sformatf("%s zero", e.tag), {31'b0, result_equal_zero}, {31'b0, e.zero});
                        checkOutput($sformatf("%s illegal", e.tag), {31'b0, illegal_op}, {31'b0, e.ill});
                        checkOutput($sformatf("%s latency", e.tag), cycleCnt - e.acc, e.lat);
                    end
                end
                prevValid = out_valid;
                prevTaken = out_valid && out_ready;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        #12;
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("reset result", result, 32'h0);
        checkOutput("reset zero", {31'b0, result_equal_zero}, 32'h1);
        checkOutput("reset illegal", {31'b0, illegal_op}, 32'h0);
        checkOutput("reset in_ready", {31'b0, in_ready}, 32'h1);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("ADD", C_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1);
        applyStimulus("SUB", C_SUB, 32'h5, 32'h5, 32'h0, 1'b0, 1);
        applyStimulus("SLL", C_SLL, 32'h1, 32'd33, 32'h2, 1'b0, 1);
        applyStimulus("SRA", C_SRA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1);
        applyStimulus("SRL", C_SRL, 32'h80000000, 32'd36, 32'h08000000, 1'b0, 1);
        applyStimulus("SLTU", C_SLTU, 32'h1, 32'hFFFFFFFF, 32'h1, 1'b0, 1);
        applyStimulus("SLT", C_SLT, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 1);
        applyStimulus("SEQ", C_SEQ, 32'h1234, 32'h1234, 32'h1, 1'b0, 1);
        applyStimulus("XOR", C_XOR, 32'h0F0F00FF, 32'h00FF0F0F, 32'h0FF00FF0, 1'b0, 1);
        applyStimulus("OR", C_OR, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1);
        applyStimulus("AND", C_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1);
        applyStimulus("ILL1F", 5'b11111, 32'h5, 32'h6, 32'h0, 1'b1, 1);
        applyStimulus("ILL00", 5'b00000, 32'h5, 32'h6, 32'h0, 1'b1, 1);

`ifdef ALU_SEQ_MULDIV_EN
        applyStimulus("MUL", C_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b0, 34);
        applyStimulus("MULH", C_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 34);
        applyStimulus("MULHU", C_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34);
        applyStimulus("MULHneg", C_MULH, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 1'b0, 34);
        applyStimulus("DIV", C_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 1'b0, 34);
        applyStimulus("REM", C_REM, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 1'b0, 34);
        applyStimulus("DIVU", C_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34);
        applyStimulus("REMU", C_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 34);
        applyStimulus("DIVU/0", C_DIVU, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1'b0, 1);
        applyStimulus("REM/0", C_REM, 32'd9, 32'h0, 32'd9, 1'b0, 1);
        applyStimulus("DIVovf", C_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
        applyStimulus("REMovf", C_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1);
`else
        applyStimulus("MULoff", C_MUL, 32'h3, 32'h5, 32'h0, 1'b1, 1);
        applyStimulus("DIVoff", C_DIV, 32'h9, 32'h3, 32'h0, 1'b1, 1);
        applyStimulus("REMUoff", C_REMU, 32'h9, 32'h4, 32'h0, 1'b1, 1);
`endif

        // Backpressure: result held and no accept while the consumer stalls.
        waitDrain();
        out_ready = 1'b0;
        applyStimulus("BPADD", C_ADD, 32'h11, 32'h22, 32'h33, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput("bp out_valid", {31'b0, out_valid}, 32'h1);
            checkOutput("bp result", result, 32'h33);
            checkOutput("bp in_ready", {31'b0, in_ready}, 32'h0);
        end
        @(negedge clk);
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        alu_function = C_SUB;
        operand_a    = 32'd10;
        operand_b    = 32'd3;
        #1;
        checkOutput("b2b in_ready", {31'b0, in_ready}, 32'h1);
        pushExpect("B2BSUB", 32'd7, 1'b0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Reset while a result is waiting in DONE.
        waitDrain();
        out_ready = 1'b0;
        applyStimulus("RSTADD", C_ADD, 32'h40, 32'h2, 32'h42, 1'b0, 1);
        @(negedge clk);
        #1;
        checkOutput("hold before reset", {31'b0, out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("rst in_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("rst result", result, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("POSTADD", C_ADD, 32'h1, 32'h1, 32'h2, 1'b0, 1);

`ifdef ALU_SEQ_MULDIV_EN
        // Reset in the tenth BUSY cycle of a DIV: the operation must vanish.
        waitDrain();
        @(negedge clk);
        in_valid     = 1'b1;
        alu_function = C_DIV;
        operand_a    = 32'd100;
        operand_b    = 32'd7;
        #1;
        checkOutput("div accept ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("busy in_ready", {31'b0, in_ready}, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("busy rst out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("busy rst in_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("busy rst zero", {31'b0, result_equal_zero}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("POSTDIVU", C_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34);
        applyStimulus("POSTREMU", C_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 34);
`endif

        waitDrain();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
